pc_redirect_ras: RTL and testbench
==================================

// Module: pc_redirect_ras
// PURPOSE
// Next-generation PC redirect unit. Resolves conditional branches, calls and returns.
// Issues one registered redirect (target PC plus valid pulse) to the fetch stage.
// Holds return addresses in an internal circular return-address stack (RAS), so RET needs no data-memory stack.
// Sits between the ID/EX register and fetch. Waits for ALU flags when a branch arrives before they are ready.
// PARAMETERS
// ADDR_W     16  PC width in bits
// CALL_W     12  call-target immediate width; upper ADDR_W-CALL_W bits come from pc_in
// RAS_DEPTH  8   RAS entries; power of 2, >=2
// PORTS
// clk            in   1       clock; all state updates on posedge
// rst            in   1       synchronous, active-high reset
// req_valid      in   1       control-flow instruction presented this cycle
// branch         in   1       request is a branch
// branch_cond    in   3       EQ=0 LT=1 GT=2 O=3 NE=4 GEQ=5 LEQ=6 T=7
// call           in   1       request is a call
// ret            in   1       request is a return
// pc_in          in   ADDR_W  PC of the requesting instruction
// sign_ext       in   ADDR_W  signed branch offset
// call_target    in   CALL_W  call immediate
// flags          in   3       {Z,V,N} from ALU
// flags_valid    in   1       flags valid this cycle
// flush          in   1       abandon a pending branch
// stall          out  1       hold the pipe; high in WAIT_FLAGS
// redirect_valid out  1       1-cycle pulse: fetch from redirect_pc
// redirect_pc    out  ADDR_W  target PC
// ras_empty      out  1       RAS holds 0 entries
// ras_full       out  1       RAS holds RAS_DEPTH entries
// ras_ovf        out  1       sticky: push while full
// ras_unf        out  1       sticky: pop while empty
// BEHAVIOUR
// Reset: outputs 0, FSM=IDLE, RAS count=0, pointers=0, sticky bits cleared. Reset mid-WAIT_FLAGS drops the branch.
// Priority when several request bits are high: branch > call > ret. The lower-priority bits are ignored.
// Targets are computed mod 2^ADDR_W:
//   branch: pc_in+1+sign_ext
//   call:   {pc_in[ADDR_W-1:CALL_W], call_target}
//   ret:    top of RAS
// Call pushes pc_in+1 to the RAS.
// Branch taken conditions:
//   EQ Z;  LT N&~V;  GT ~Z&~N&~V;  O V;  NE ~Z;  GEQ V|~N;  LEQ Z|(N&~V);  T 1.
// Latency: redirect_valid/redirect_pc are registered and appear the cycle after resolution.
//   A not-taken branch produces no pulse.
// FSM states: IDLE, WAIT_FLAGS.
//   IDLE, req_valid & branch & flags_valid: resolve now; stay IDLE.
//   IDLE, req_valid & branch & ~flags_valid: latch target and cond; go WAIT_FLAGS; stall=1 combinationally the same cycle.
//   IDLE, req_valid & call or ret (not branch): resolve immediately; flags ignored.
//   WAIT_FLAGS: stall=1; req_valid ignored.
//     On flags_valid: resolve with latched cond; go IDLE.
//     On flush: go IDLE; no redirect; RAS untouched. flush has priority over flags_valid.
// RAS push when full: overwrite the oldest entry (circular). Count stays RAS_DEPTH; ras_ovf <= 1.
// RAS pop when empty: redirect still pulses with redirect_pc=0; ras_unf <= 1; count stays 0.
// Only one push or pop per cycle (guaranteed by priority). Pointers wrap mod RAS_DEPTH.
// redirect_pc holds its last value when no pulse is issued.
// STRUCTURE
// Package pc_redirect_pkg: br_cond_e enum (3-bit codes above); FLAG_Z=2, FLAG_V=1, FLAG_N=0; fsm_state_e.
// Sub-module ras_stack #(ADDR_W,RAS_DEPTH)
//   Ports: clk, rst, push, pop, push_data, top, empty, full, ovf, unf.
//   Circular buffer with top pointer and saturating count.
// Top level holds the FSM, condition evaluation, target adders and output registers.
// TESTING
// 1 BEQ, pc_in=0x0010, sign_ext=0xFFFC, flags=100, flags_valid=1 -> next cycle redirect_valid=1, redirect_pc=0x000D.
// 2 BGT with flags_valid=0 for 3 cycles, then flags=000 -> stall=1 for those 3 cycles; one pulse, correct target, stall drops.
// 3 CALL pc_in=0x3005, call_target=0x123, then RET -> redirects 0x3123 then 0x3006; ras_empty=1 after.
// 4 9 CALLs (RAS_DEPTH=8), pc 0x0100..0x0108, then 8 RETs -> ras_ovf=1; returns 0x0109..0x0102; 9th RET gives 0x0000, ras_unf=1.
// 5 Branch in WAIT_FLAGS, flush and flags_valid same cycle -> no redirect; FSM IDLE; RAS count unchanged.
// 6 rst asserted in WAIT_FLAGS with 2 RAS entries -> next cycle all outputs 0, ras_empty=1, sticky bits 0.

Source files
------------

// File: rtl/pc_redirect_pkg.sv
// Shared types for the PC redirect unit: branch condition codes, ALU flag bit positions, FSM states.
// Also holds the branch-taken evaluation so the FSM stays free of flag decoding.
package pc_redirect_pkg;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_LT  = 3'd1,
        BR_GT  = 3'd2,
        BR_O   = 3'd3,
        BR_NE  = 3'd4,
        BR_GEQ = 3'd5,
        BR_LEQ = 3'd6,
        BR_T   = 3'd7
    } br_cond_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        ST_IDLE       = 1'b0,
        ST_WAIT_FLAGS = 1'b1
    } fsm_state_e;

    function automatic logic cond_taken(input br_cond_e cond, input logic [2:0] flags);
        logic z, v, n;
        z = flags[FLAG_Z];
        v = flags[FLAG_V];
        n = flags[FLAG_N];
        case (cond)
            BR_EQ:   cond_taken = z;
            BR_LT:   cond_taken = n & ~v;
            BR_GT:   cond_taken = ~z & ~n & ~v;
            BR_O:    cond_taken = v;
            BR_NE:   cond_taken = ~z;
            BR_GEQ:  cond_taken = v | ~n;
            BR_LEQ:  cond_taken = z | (n & ~v);
            default: cond_taken = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full, pop on empty reads 0.
// Latency: top is combinational from current state; push/pop update on the next clock edge.
// Backpressure: none; overflow/underflow are recorded in sticky flags instead of being refused.
module ras_stack #(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    // wr_ptr is the next free slot, so the newest entry lives one below it
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  count;

    assign top_ptr = wr_ptr - PTR_W'(1);
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RAS_DEPTH));
    assign top     = empty ? '0 : mem[top_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
            if (full) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                wr_ptr <= top_ptr;
                count  <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_redirect_ras.sv
// PC redirect unit: resolves branches, calls and returns into a single registered fetch redirect.
// Latency: redirect appears the cycle after resolution; branches without flags wait in WAIT_FLAGS.
// Backpressure: stall is raised while a branch waits for flags, including the cycle it arrives.
module pc_redirect_ras
    import pc_redirect_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int CALL_W    = 12,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              branch,
    input  logic [2:0]        branch_cond,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] sign_ext,
    input  logic [CALL_W-1:0] call_target,
    input  logic [2:0]        flags,
    input  logic              flags_valid,
    input  logic              flush,
    output logic              stall,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf
);

    fsm_state_e        state, state_nxt;
    logic [ADDR_W-1:0] lat_tgt;
    br_cond_e          lat_cond;
    logic              latch_en;

    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] call_tgt;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] ras_top;

    logic              pulse;
    logic [ADDR_W-1:0] pulse_tgt;
    logic              ras_push;
    logic              ras_pop;

    assign br_tgt   = pc_in + ADDR_W'(1) + sign_ext;
    assign call_tgt = {pc_in[ADDR_W-1:CALL_W], call_target};
    assign ret_addr = pc_in + ADDR_W'(1);

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (ret_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        pulse     = 1'b0;
        pulse_tgt = redirect_pc;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        latch_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                // branch > call > ret; lower-priority request bits are dropped
                if (req_valid && branch) begin
                    if (flags_valid) begin
                        pulse     = cond_taken(br_cond_e'(branch_cond), flags);
                        pulse_tgt = br_tgt;
                    end else begin
                        stall     = 1'b1;
                        latch_en  = 1'b1;
                        state_nxt = ST_WAIT_FLAGS;
                    end
                end else if (req_valid && call) begin
                    pulse     = 1'b1;
                    pulse_tgt = call_tgt;
                    ras_push  = 1'b1;
                end else if (req_valid && ret) begin
                    pulse     = 1'b1;
                    pulse_tgt = ras_top;
                    ras_pop   = 1'b1;
                end
            end
            ST_WAIT_FLAGS: begin
                stall = 1'b1;
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (flags_valid) begin
                    pulse     = cond_taken(lat_cond, flags);
                    pulse_tgt = lat_tgt;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            lat_tgt        <= '0;
            lat_cond       <= BR_EQ;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_nxt;
            redirect_valid <= pulse;
            if (latch_en) begin
                lat_tgt  <= br_tgt;
                lat_cond <= br_cond_e'(branch_cond);
            end
            if (pulse) begin
                redirect_pc <= pulse_tgt;
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect_ras.sv
// Directed bench for pc_redirect_ras: a branch-condition vector table plus hand-written multi-cycle sequences.
module tb_pc_redirect_ras;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, branch, call, ret, flags_valid, flush;
    logic [2:0]  branch_cond, flags;
    logic [15:0] pc_in, sign_ext;
    logic [11:0] call_target;
    logic        stall, redirect_valid, ras_empty, ras_full, ras_ovf, ras_unf;
    logic [15:0] redirect_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_redirect_ras #(.ADDR_W(16), .CALL_W(12), .RAS_DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .branch         (branch),
        .branch_cond    (branch_cond),
        .call           (call),
        .ret            (ret),
        .pc_in          (pc_in),
        .sign_ext       (sign_ext),
        .call_target    (call_target),
        .flags          (flags),
        .flags_valid    (flags_valid),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ras_empty      (ras_empty),
        .ras_full       (ras_full),
        .ras_ovf        (ras_ovf),
        .ras_unf        (ras_unf)
    );

    typedef struct {
        logic [2:0]  cond;
        logic [15:0] pc;
        logic [15:0] sext;
        logic [2:0]  flg;
        logic        also_call;
        logic        exp_taken;
        logic [15:0] tgt;
    } bvec_t;

    bvec_t vt [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0;
        branch      = 1'b0;
        branch_cond = 3'd0;
        call        = 1'b0;
        ret         = 1'b0;
        pc_in       = 16'h0;
        sign_ext    = 16'h0;
        call_target = 12'h0;
        flags       = 3'b000;
        flags_valid = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_call(input logic [15:0] pc, input logic [11:0] ct);
        idle_inputs();
        req_valid   = 1'b1;
        call        = 1'b1;
        pc_in       = pc;
        call_target = ct;
        tick();
        idle_inputs();
    endtask

    task automatic do_ret();
        idle_inputs();
        req_valid = 1'b1;
        ret       = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic start_wait_branch(input logic [2:0] cond, input logic [15:0] pc, input logic [15:0] sext);
        idle_inputs();
        req_valid   = 1'b1;
        branch      = 1'b1;
        branch_cond = cond;
        pc_in       = pc;
        sign_ext    = sext;
        #1;
        chk("wait_entry_stall", stall, 1'b1);
        tick();
        idle_inputs();
    endtask

    initial begin
        logic [15:0] last_pc;
        rst = 1'b1;
        idle_inputs();

        vt[0]  = '{3'd0, 16'h0010, 16'hFFFC, 3'b100, 1'b0, 1'b1, 16'h000D};
        vt[1]  = '{3'd0, 16'h0020, 16'h0004, 3'b000, 1'b0, 1'b0, 16'h0025};
        vt[2]  = '{3'd1, 16'h0030, 16'h0002, 3'b001, 1'b0, 1'b1, 16'h0033};
        vt[3]  = '{3'd1, 16'h0040, 16'h0002, 3'b011, 1'b0, 1'b0, 16'h0043};
        vt[4]  = '{3'd2, 16'hFFFF, 16'h0005, 3'b000, 1'b0, 1'b1, 16'h0005};
        vt[5]  = '{3'd2, 16'h0050, 16'h0001, 3'b100, 1'b0, 1'b0, 16'h0052};
        vt[6]  = '{3'd3, 16'h1000, 16'h8000, 3'b010, 1'b0, 1'b1, 16'h9001};
        vt[7]  = '{3'd3, 16'h1000, 16'h0010, 3'b000, 1'b0, 1'b0, 16'h1011};
        vt[8]  = '{3'd4, 16'h2000, 16'hFFFF, 3'b000, 1'b0, 1'b1, 16'h2000};
        vt[9]  = '{3'd4, 16'h2000, 16'h0001, 3'b100, 1'b0, 1'b0, 16'h2002};
        vt[10] = '{3'd5, 16'h0100, 16'h0000, 3'b001, 1'b0, 1'b0, 16'h0101};
        vt[11] = '{3'd5, 16'h0200, 16'h0003, 3'b011, 1'b0, 1'b1, 16'h0204};
        vt[12] = '{3'd6, 16'h0300, 16'h0000, 3'b100, 1'b0, 1'b1, 16'h0301};
        vt[13] = '{3'd6, 16'h0400, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h0401};
        vt[14] = '{3'd7, 16'h7FFF, 16'h0000, 3'b000, 1'b0, 1'b1, 16'h8000};
        vt[15] = '{3'd2, 16'h0500, 16'h0010, 3'b000, 1'b1, 1'b1, 16'h0511};
        vt[16] = '{3'd6, 16'h0600, 16'h0002, 3'b001, 1'b0, 1'b1, 16'h0603};
        vt[17] = '{3'd2, 16'h0700, 16'h0000, 3'b001, 1'b0, 1'b0, 16'h0701};

        // reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_stall", stall, 1'b0);
        chk("rst_rv", redirect_valid, 1'b0);
        chk("rst_pc", redirect_pc, 16'h0);
        chk("rst_empty", ras_empty, 1'b1);
        chk("rst_full", ras_full, 1'b0);
        chk("rst_ovf", ras_ovf, 1'b0);
        chk("rst_unf", ras_unf, 1'b0);

        // single-cycle branch resolution table
        last_pc = 16'h0;
        for (int i = 0; i < 18; i++) begin
            idle_inputs();
            req_valid   = 1'b1;
            branch      = 1'b1;
            call        = vt[i].also_call;
            branch_cond = vt[i].cond;
            pc_in       = vt[i].pc;
            sign_ext    = vt[i].sext;
            flags       = vt[i].flg;
            flags_valid = 1'b1;
            #1;
            chk($sformatf("vec%0d_stall", i), stall, 1'b0);
            tick();
            if (vt[i].exp_taken) last_pc = vt[i].tgt;
            chk($sformatf("vec%0d_rv", i), redirect_valid, vt[i].exp_taken);
            chk($sformatf("vec%0d_pc", i), redirect_pc, last_pc);
            chk($sformatf("vec%0d_empty", i), ras_empty, 1'b1);
        end
        idle_inputs();
        tick();
        chk("tbl_rv_drop", redirect_valid, 1'b0);

        // branch waiting three cycles for flags; a call during the wait is ignored
        start_wait_branch(3'd2, 16'h0020, 16'h0010);
        chk("wait_c0_rv", redirect_valid, 1'b0);
        req_valid = 1'b1;
        call      = 1'b1;
        pc_in     = 16'h4444;
        #1;
        chk("wait_c1_stall", stall, 1'b1);
        tick();
        idle_inputs();
        chk("wait_c1_rv", redirect_valid, 1'b0);
        chk("wait_call_ignored", ras_empty, 1'b1);
        #1;
        chk("wait_c2_stall", stall, 1'b1);
        tick();
        flags_valid = 1'b1;
        flags       = 3'b000;
        #1;
        chk("wait_resolve_stall", stall, 1'b1);
        tick();
        idle_inputs();
        chk("wait_rv", redirect_valid, 1'b1);
        chk("wait_pc", redirect_pc, 16'h0031);
        chk("wait_stall_drop", stall, 1'b0);
        tick();
        chk("wait_single_pulse", redirect_valid, 1'b0);

        // call then return
        do_call(16'h3005, 12'h123);
        chk("call_rv", redirect_valid, 1'b1);
        chk("call_pc", redirect_pc, 16'h3123);
        chk("call_not_empty", ras_empty, 1'b0);
        do_ret();
        chk("ret_rv", redirect_valid, 1'b1);
        chk("ret_pc", redirect_pc, 16'h3006);
        chk("ret_empty", ras_empty, 1'b1);

        // overflow wrap and underflow
        do_reset();
        for (int k = 0; k < 9; k++) begin
            do_call(16'h0100 + 16'(k), 12'h0AB);
            if (k == 7) begin
                chk("ovf_full8", ras_full, 1'b1);
                chk("ovf_not_yet", ras_ovf, 1'b0);
            end
        end
        chk("ovf_set", ras_ovf, 1'b1);
        chk("ovf_full9", ras_full, 1'b1);
        chk("ovf_call_pc", redirect_pc, 16'h00AB);
        for (int k = 0; k < 8; k++) begin
            do_ret();
            chk($sformatf("ovf_ret%0d_pc", k), redirect_pc, 16'h0109 - 16'(k));
        end
        chk("ovf_drained_empty", ras_empty, 1'b1);
        chk("unf_not_yet", ras_unf, 1'b0);
        do_ret();
        chk("unf_rv", redirect_valid, 1'b1);
        chk("unf_pc", redirect_pc, 16'h0000);
        chk("unf_set", ras_unf, 1'b1);
        chk("unf_still_empty", ras_empty, 1'b1);

        // flush beats flags_valid in WAIT_FLAGS
        do_reset();
        do_call(16'h0A00, 12'h050);
        start_wait_branch(3'd7, 16'h0B00, 16'h0004);
        flush       = 1'b1;
        flags_valid = 1'b1;
        tick();
        idle_inputs();
        chk("flush_rv", redirect_valid, 1'b0);
        chk("flush_pc_held", redirect_pc, 16'h0050);
        chk("flush_stall", stall, 1'b0);
        chk("flush_ras_kept", ras_empty, 1'b0);
        req_valid   = 1'b1;
        branch      = 1'b1;
        branch_cond = 3'd7;
        pc_in       = 16'h0C00;
        flags_valid = 1'b1;
        tick();
        idle_inputs();
        chk("flush_idle_rv", redirect_valid, 1'b1);
        chk("flush_idle_pc", redirect_pc, 16'h0C01);
        do_ret();
        chk("flush_ret_pc", redirect_pc, 16'h0A01);

        // reset while waiting with two RAS entries and sticky underflow set
        do_reset();
        do_ret();
        chk("rst6_unf_pre", ras_unf, 1'b1);
        do_call(16'h0010, 12'h111);
        do_call(16'h0020, 12'h222);
        start_wait_branch(3'd7, 16'h0030, 16'h0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst6_stall", stall, 1'b0);
        chk("rst6_rv", redirect_valid, 1'b0);
        chk("rst6_pc", redirect_pc, 16'h0);
        chk("rst6_empty", ras_empty, 1'b1);
        chk("rst6_full", ras_full, 1'b0);
        chk("rst6_ovf", ras_ovf, 1'b0);
        chk("rst6_unf", ras_unf, 1'b0);
        flags_valid = 1'b1;
        tick();
        idle_inputs();
        chk("rst6_branch_dropped", redirect_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
